vending_fsm_param: RTL
======================

# vending_fsm_param

Parametrised, fully synchronous successor to the vending-machine state/total calculator. It is a single clocked FSM that owns the credit balance, per-item stock counters, an inactivity timeout and a greedy change-return sequencer. Item count, coin count, total width, timeout length and stock depth are all parameters. It sits between the coin/button front end and the dispenser/coin-hopper drivers in the vending-machine top.

## Interface
- NUM_ITEMS, 4, number of items
- NUM_COINS, 3, number of coin denominations
- TOTAL_BITS, 31, width of balance, prices and coin values
- WAIT_CYCLES, 100, inactivity timeout in cycles (≥1)
- STOCK_BITS, 4, width of each stock counter
- STOCK_INIT, 10, stock loaded at reset/restock (must fit STOCK_BITS)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- i_input_coin  in  NUM_COINS  coin insert strobes, sampled each cycle
- i_select_item  in  NUM_ITEMS  item select strobes
- i_trigger_return  in  1  request change return
- i_restock  in  1  reload all stock to STOCK_INIT
- item_price  in  NUM_ITEMS*TOTAL_BITS  flattened prices, item i at [i*TOTAL_BITS +: TOTAL_BITS]
- coin_value  in  NUM_COINS*TOTAL_BITS  flattened values, strictly ascending with index
- o_available_item  out  NUM_ITEMS  combinational: state IDLE, price[i] ≤ balance and stock[i] ≠ 0
- o_output_item  out  NUM_ITEMS  registered one-hot dispense pulse
- o_return_coin  out  NUM_COINS  registered one-hot change pulse
- o_balance  out  TOTAL_BITS  registered current balance
- o_sold_out  out  NUM_ITEMS  combinational: stock[i] == 0
- o_reject  out  1  registered one-cycle pulse on rejected coin insert
- o_busy  out  1  high while in RETURN

## Operation
- States: IDLE, RETURN. Reset → IDLE, balance 0, all stock STOCK_INIT, timer WAIT_CYCLES, all registered outputs 0.
- IDLE priority per cycle (only highest applies): coin insert > item select > return trigger/timeout > restock.
- Coin insert (any bit set): sum = Σ coin_value[j] over set bits, computed in TOTAL_BITS+NUM_COINS bits. If balance+sum ≤ 2^TOTAL_BITS−1: balance += sum, timer reloads. Otherwise balance unchanged, o_reject pulses; timer not reloaded.
- Item select: only lowest-index set bit i considered. If price[i] ≤ balance and stock[i] ≠ 0: o_output_item = 1<<i for one cycle, balance −= price[i], stock[i] −= 1, timer reloads. Otherwise ignored silently.
- Timer: decrements each IDLE cycle with balance ≠ 0 and no accepted coin/select; held at WAIT_CYCLES while balance = 0. Entering RETURN when timer reaches 0 with balance ≠ 0.
- i_trigger_return with balance ≠ 0 → RETURN; with balance 0 → no effect.
- i_restock: all stock ← STOCK_INIT; ignored in RETURN.
- RETURN: each cycle pick highest j with coin_value[j] ≤ balance; o_return_coin = 1<<j, balance −= coin_value[j]. When no coin fits: balance ← 0 (residue below smallest coin forfeited), o_return_coin = 0, timer reloads, → IDLE. All coin/select/trigger inputs ignored (coins inserted here are not credited and not rejected).
- Reset mid-RETURN: immediate reset values; no further change pulses.

## Timing
- Input sampled at edge N → o_balance, o_output_item, o_reject valid after edge N; pulses last exactly one cycle.
- Trigger at edge N → state RETURN after edge N; first o_return_coin after edge N+1; k coins occupy edges N+1..N+k; IDLE after edge N+k+1 (o_busy low).
- Timeout: last accepted activity at edge N with timer reloaded → RETURN after edge N+WAIT_CYCLES.
- o_available_item/o_sold_out follow registered state/balance/stock combinationally; forced 0/valid respectively in RETURN for o_available_item.

## Test plan
Setup: prices 400/500/1000/2000, coins 100/500/1000, WAIT_CYCLES=10, STOCK_INIT=2.
- Reset, i_input_coin=3'b100 one cycle → o_balance=1000, o_available_item=4'b0111, o_reject=0.
- Balance 1000, i_select_item=4'b0110 → o_output_item=4'b0010 one cycle, balance 500, only item 1 (lowest) dispensed.
- Balance 2000, select item0 twice → balance 1200, o_sold_out[0]=1; third select item0 → no pulse, balance 1200; i_restock → o_sold_out[0]=0.
- Balance 1600, i_trigger_return → o_return_coin 3'b100, 3'b010, 3'b001 on consecutive cycles, then o_busy=0, balance 0; coin inserted during RETURN not credited.
- Insert 500 then idle → return 3'b010 exactly 10 cycles later +1; insert at cycle 5 reloads timer (return delayed accordingly).
- TOTAL_BITS=11, balance 1900, insert 1000 → o_reject pulse, balance 1900; reset asserted mid-RETURN → balance 0, IDLE next cycle.

Source files
------------

// File: rtl/vending_fsm_param.sv
// Parametrised vending-machine controller: credit balance, per-item stock, inactivity timeout
// and a greedy change-return sequencer in a single synchronous FSM.
module vending_fsm_param #(
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned NUM_COINS   = 3,
  parameter int unsigned TOTAL_BITS  = 31,
  parameter int unsigned WAIT_CYCLES = 100,
  parameter int unsigned STOCK_BITS  = 4,
  parameter int unsigned STOCK_INIT  = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic                            i_restock,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] item_price,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic [TOTAL_BITS-1:0]           o_balance,
  output logic [NUM_ITEMS-1:0]            o_sold_out,
  output logic                            o_reject,
  output logic                            o_busy
);

  localparam int unsigned TimerBits = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned SumBits   = TOTAL_BITS + NUM_COINS;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StReturn = 1'b1;

  localparam logic [TimerBits-1:0]  TimerLoad = TimerBits'(WAIT_CYCLES);
  localparam logic [STOCK_BITS-1:0] StockLoad = STOCK_BITS'(STOCK_INIT);

  logic [0:0]            state_q, state_d;
  logic [TOTAL_BITS-1:0] balance_q, balance_d;
  logic [TimerBits-1:0]  timer_q, timer_d;
  logic [STOCK_BITS-1:0] stock_q [NUM_ITEMS];
  logic [STOCK_BITS-1:0] stock_d [NUM_ITEMS];
  logic [NUM_ITEMS-1:0]  item_q, item_d;
  logic [NUM_COINS-1:0]  coin_q, coin_d;
  logic                  reject_q, reject_d;

  logic [TOTAL_BITS-1:0] price [NUM_ITEMS];
  logic [TOTAL_BITS-1:0] value [NUM_COINS];

  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
    assign price[gi] = item_price[gi*TOTAL_BITS +: TOTAL_BITS];
  end
  for (genvar gj = 0; gj < NUM_COINS; gj++) begin : g_value
    assign value[gj] = coin_value[gj*TOTAL_BITS +: TOTAL_BITS];
  end

  logic [SumBits-1:0]    coin_sum, new_total;
  logic                  coin_any, coin_fits;
  logic [NUM_ITEMS-1:0]  avail_raw, sel_onehot;
  logic                  sel_any, sel_ok;
  logic [TOTAL_BITS-1:0] sel_price;
  logic [NUM_COINS-1:0]  ret_onehot;
  logic [TOTAL_BITS-1:0] ret_value;
  logic                  ret_found;

  always_comb begin
    coin_sum = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (i_input_coin[j]) coin_sum = coin_sum + SumBits'(value[j]);
    end
    new_total = SumBits'(balance_q) + coin_sum;
    coin_any  = |i_input_coin;
    // Overflow of the balance register shows up as any set bit above TOTAL_BITS.
    coin_fits = (new_total[SumBits-1:TOTAL_BITS] == '0);
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_raw[i] = (price[i] <= balance_q) && (stock_q[i] != '0);
    end
    sel_onehot = i_select_item & (~i_select_item + NUM_ITEMS'(1));
    sel_any    = |i_select_item;
    sel_ok     = |(sel_onehot & avail_raw);
    sel_price  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_onehot[i]) sel_price = price[i];
    end
  end

  // Ascending coin values: the last fitting index is the largest coin.
  always_comb begin
    ret_onehot = '0;
    ret_value  = '0;
    ret_found  = 1'b0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (value[j] <= balance_q) begin
        ret_onehot = NUM_COINS'(1) << j;
        ret_value  = value[j];
        ret_found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    balance_d = balance_q;
    timer_d   = timer_q;
    stock_d   = stock_q;
    item_d    = '0;
    coin_d    = '0;
    reject_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (balance_q == '0) begin
          timer_d = TimerLoad;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TimerBits'(1);
        end
        if (coin_any) begin
          if (coin_fits) begin
            balance_d = new_total[TOTAL_BITS-1:0];
            timer_d   = TimerLoad;
          end else begin
            reject_d = 1'b1;
          end
        end else if (sel_any) begin
          if (sel_ok) begin
            item_d    = sel_onehot;
            balance_d = balance_q - sel_price;
            timer_d   = TimerLoad;
            for (int i = 0; i < NUM_ITEMS; i++) begin
              if (sel_onehot[i]) stock_d[i] = stock_q[i] - STOCK_BITS'(1);
            end
          end
        end else if ((balance_q != '0) &&
                     (i_trigger_return || (timer_q <= TimerBits'(1)))) begin
          state_d = StReturn;
        end else if (i_restock && !i_trigger_return) begin
          for (int i = 0; i < NUM_ITEMS; i++) stock_d[i] = StockLoad;
        end
      end
      StReturn: begin
        if (ret_found) begin
          coin_d    = ret_onehot;
          balance_d = balance_q - ret_value;
        end else begin
          balance_d = '0;
          timer_d   = TimerLoad;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      balance_q <= '0;
      timer_q   <= TimerLoad;
      item_q    <= '0;
      coin_q    <= '0;
      reject_q  <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= StockLoad;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      timer_q   <= timer_d;
      item_q    <= item_d;
      coin_q    <= coin_d;
      reject_q  <= reject_d;
      for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) o_sold_out[i] = (stock_q[i] == '0);
    o_available_item = (state_q == StIdle) ? avail_raw : '0;
  end

  assign o_output_item = item_q;
  assign o_return_coin = coin_q;
  assign o_balance     = balance_q;
  assign o_reject      = reject_q;
  assign o_busy        = (state_q == StReturn);

endmodule
